// File: rtl/gpio_comm_bridge.sv
// -----------------------------------------------------------------------------
// gpio_comm_bridge
//
// Purpose:
//   Moves payload words between a host-side streaming interface and a core
//   that only exposes a 32-bit GPIO bank. Two toggle handshakes share the bank:
//     downlink (host -> core): bridge drives dn_data + dn_req toggle on gpio_in,
//                              core answers with dn_ack toggle on gpio_out.
//     uplink   (core -> host): core drives up_data + up_req toggle on gpio_out,
//                              bridge answers with up_ack toggle on gpio_in.
//   A TX FIFO buffers host writes and an RX FIFO buffers core uploads.
//
// Ports:
//   clk            single clock
//   resetn         asynchronous active-low reset
//   flush          synchronous clear of both FIFOs (handshake state kept)
//   host_wr_*      valid/ready push into TX FIFO
//   host_rd_*      valid/ready pop from RX FIFO (first-word fall-through)
//   gpio_out       core GPIO outputs  {.., dn_ack, up_req, up_data}
//   gpio_in        core GPIO inputs   {0.., up_ack, dn_req, dn_data}
//   tx_level       TX FIFO occupancy
//   rx_level       RX FIFO occupancy
// -----------------------------------------------------------------------------
module gpio_comm_bridge #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH      = 4,
  parameter int pSYNC       = 0,
  localparam int LW         = $clog2(pDEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   host_wr_valid,
  input  logic [pDATA_WIDTH-1:0] host_wr_data,
  output logic                   host_wr_ready,
  output logic                   host_rd_valid,
  output logic [pDATA_WIDTH-1:0] host_rd_data,
  input  logic                   host_rd_ready,
  input  logic [31:0]            gpio_out,
  output logic [31:0]            gpio_in,
  output logic [LW-1:0]          tx_level,
  output logic [LW-1:0]          rx_level
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_FULL = LW'(pDEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } dn_state_e;

  // ---------------------------------------------------------------------------
  // gpio_out conditioning
  // ---------------------------------------------------------------------------
  logic [31:0] gpio_s;

  if (pSYNC == 2) begin : g_sync
    logic [31:0] sync1_q;
    logic [31:0] sync2_q;

    // Two-stage synchronizer on the whole core output bank.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync1_q <= 32'h0000_0000;
        sync2_q <= 32'h0000_0000;
      end else begin
        sync1_q <= gpio_out;
        sync2_q <= sync1_q;
      end
    end

    assign gpio_s = sync2_q;
  end else begin : g_nosync
    assign gpio_s = gpio_out;
  end

  logic [pDATA_WIDTH-1:0] up_data_s;
  logic                   up_req_s;
  logic                   dn_ack_s;
  logic                   unused_gpio_s;

  assign up_data_s     = gpio_s[pDATA_WIDTH-1:0];
  assign up_req_s      = gpio_s[pDATA_WIDTH];
  assign dn_ack_s      = gpio_s[pDATA_WIDTH+1];
  // Upper gpio_out bits carry nothing for this bridge.
  assign unused_gpio_s = ^gpio_s;

  // ---------------------------------------------------------------------------
  // TX FIFO (host -> core)
  // ---------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] tx_mem_q [pDEPTH];
  logic [AW-1:0]          tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]          tx_rd_ptr_q, tx_rd_ptr_d;
  logic [LW-1:0]          tx_level_q,  tx_level_d;
  logic                   tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;

  dn_state_e              state_q;

  assign tx_full_s  = (tx_level_q == LVL_FULL);
  assign tx_empty_s = (tx_level_q == LVL_ZERO);
  // flush outranks both push and pop in the same cycle.
  assign tx_push_s  = host_wr_valid && !tx_full_s && !flush;
  assign tx_pop_s   = (state_q == ST_IDLE) && !tx_empty_s && !flush;

  // TX pointer and level next-state.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    if (flush) begin
      tx_wr_ptr_d = PTR_ZERO;
      tx_rd_ptr_d = PTR_ZERO;
      tx_level_d  = LVL_ZERO;
    end else begin
      if (tx_push_s) begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
      end else begin
        tx_wr_ptr_d = tx_wr_ptr_q;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
      end else begin
        tx_rd_ptr_d = tx_rd_ptr_q;
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_level_d = tx_level_q + LVL_ONE;
        2'b01:   tx_level_d = tx_level_q - LVL_ONE;
        default: tx_level_d = tx_level_q;
      endcase
    end
  end

  // TX pointer and level registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wr_ptr_q <= PTR_ZERO;
      tx_rd_ptr_q <= PTR_ZERO;
      tx_level_q  <= LVL_ZERO;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
    end
  end

  // TX storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < pDEPTH; i++) begin
        tx_mem_q[i] <= {pDATA_WIDTH{1'b0}};
      end
    end else if (tx_push_s) begin
      tx_mem_q[tx_wr_ptr_q] <= host_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Downlink FSM: presents one TX word at a time and waits for dn_ack.
  // ---------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] dn_data_q;
  logic                   dn_req_q;

  // Downlink handshake state and its registered gpio_in fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      dn_data_q <= {pDATA_WIDTH{1'b0}};
      dn_req_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_pop_s) begin
            dn_data_q <= tx_mem_q[tx_rd_ptr_q];
            dn_req_q  <= ~dn_req_q;
            state_q   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Core has caught up once its ack toggle matches our req toggle.
          if (dn_ack_s == dn_req_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (core -> host)
  // ---------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] rx_mem_q [pDEPTH];
  logic [AW-1:0]          rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]          rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0]          rx_level_q,  rx_level_d;
  logic                   rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
  logic                   up_ack_q;
  logic                   up_pend_s;

  assign rx_full_s  = (rx_level_q == LVL_FULL);
  assign rx_empty_s = (rx_level_q == LVL_ZERO);
  assign up_pend_s  = (up_req_s != up_ack_q);
  assign rx_pop_s   = !rx_empty_s && host_rd_ready && !flush;
  // A full RX may still accept when the host frees the head on the same edge;
  // the written slot equals the popped slot, which is read before the edge.
  assign rx_push_s  = up_pend_s && (!rx_full_s || rx_pop_s) && !flush;

  // RX pointer and level next-state.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_level_d  = rx_level_q;
    if (flush) begin
      rx_wr_ptr_d = PTR_ZERO;
      rx_rd_ptr_d = PTR_ZERO;
      rx_level_d  = LVL_ZERO;
    end else begin
      if (rx_push_s) begin
        rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
      end else begin
        rx_wr_ptr_d = rx_wr_ptr_q;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
      end else begin
        rx_rd_ptr_d = rx_rd_ptr_q;
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_level_d = rx_level_q + LVL_ONE;
        2'b01:   rx_level_d = rx_level_q - LVL_ONE;
        default: rx_level_d = rx_level_q;
      endcase
    end
  end

  // RX pointer and level registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wr_ptr_q <= PTR_ZERO;
      rx_rd_ptr_q <= PTR_ZERO;
      rx_level_q  <= LVL_ZERO;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
    end
  end

  // RX storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < pDEPTH; i++) begin
        rx_mem_q[i] <= {pDATA_WIDTH{1'b0}};
      end
    end else if (rx_push_s) begin
      rx_mem_q[rx_wr_ptr_q] <= up_data_s;
    end
  end

  // Uplink ack toggles on the same edge that captures up_data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      up_ack_q <= 1'b0;
    end else if (rx_push_s) begin
      up_ack_q <= ~up_ack_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign host_wr_ready = !tx_full_s;
  assign host_rd_valid = !rx_empty_s;
  assign host_rd_data  = rx_mem_q[rx_rd_ptr_q];
  assign tx_level      = tx_level_q;
  assign rx_level      = rx_level_q;

  // Assemble gpio_in from registered handshake fields; spare bits stay 0.
  always_comb begin
    gpio_in                  = 32'h0000_0000;
    gpio_in[pDATA_WIDTH-1:0] = dn_data_q;
    gpio_in[pDATA_WIDTH]     = dn_req_q;
    gpio_in[pDATA_WIDTH+1]   = up_ack_q;
  end

endmodule

// File: tb/tb_gpio_comm_bridge.sv
module tb_gpio_comm_bridge;

  logic        clk = 1'b0;
  logic        resetn;

  // instance A: pSYNC = 0
  logic        flush, wv, rr;
  logic [7:0]  wd;
  logic [31:0] go;
  logic        wr_ready, rd_valid;
  logic [7:0]  rd_data;
  logic [31:0] gi;
  logic [2:0]  txl, rxl;

  // instance B: pSYNC = 2
  logic        s2_flush, s2_wv, s2_rr;
  logic [7:0]  s2_wd;
  logic [31:0] s2_go;
  logic        s2_wr_ready, s2_rd_valid;
  logic [7:0]  s2_rd_data;
  logic [31:0] s2_gi;
  logic [2:0]  s2_txl, s2_rxl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_comm_bridge #(.pDATA_WIDTH(8), .pDEPTH(4), .pSYNC(0)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .host_wr_valid(wv), .host_wr_data(wd), .host_wr_ready(wr_ready),
    .host_rd_valid(rd_valid), .host_rd_data(rd_data), .host_rd_ready(rr),
    .gpio_out(go), .gpio_in(gi), .tx_level(txl), .rx_level(rxl)
  );

  gpio_comm_bridge #(.pDATA_WIDTH(8), .pDEPTH(4), .pSYNC(2)) u_dut_s2 (
    .clk(clk), .resetn(resetn), .flush(s2_flush),
    .host_wr_valid(s2_wv), .host_wr_data(s2_wd), .host_wr_ready(s2_wr_ready),
    .host_rd_valid(s2_rd_valid), .host_rd_data(s2_rd_data), .host_rd_ready(s2_rr),
    .gpio_out(s2_go), .gpio_in(s2_gi), .tx_level(s2_txl), .rx_level(s2_rxl)
  );

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        rr;
    logic [31:0] go;
    logic [31:0] egi;
    logic [2:0]  etx;
    logic [2:0]  erx;
    logic        ewr;
    logic        erv;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r,
                              input logic [31:0] g, input logic [31:0] eg,
                              input logic [2:0] et, input logic [2:0] er,
                              input logic ew, input logic ev, input logic [7:0] ed);
    vec_t v;
    v.wv = w; v.wd = d; v.rr = r; v.go = g; v.egi = eg;
    v.etx = et; v.erx = er; v.ewr = ew; v.erv = ev; v.erd = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       upr;
    logic [7:0] exp_q [4];

    resetn = 1'b0; flush = 1'b0; wv = 1'b0; wd = 8'h00; rr = 1'b0; go = 32'h0;
    s2_flush = 1'b0; s2_wv = 1'b0; s2_wd = 8'h00; s2_rr = 1'b0; s2_go = 32'h0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_gpio_in", gi, 32'h0);
    chk("rst_tx_level", {29'd0, txl}, 32'd0);
    chk("rst_rx_level", {29'd0, rxl}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    #1 resetn = 1'b1;
    step();

    // ---------------- pSYNC=2 uplink latency ----------------
    s2_go = 32'h0000_015A;
    step();
    chk("s2_ack_c1", {31'd0, s2_gi[9]}, 32'd0);
    step();
    chk("s2_ack_c2", {31'd0, s2_gi[9]}, 32'd0);
    step();
    chk("s2_ack_c3", {31'd0, s2_gi[9]}, 32'd1);
    chk("s2_rx_level", {29'd0, s2_rxl}, 32'd1);
    chk("s2_rd_data", {24'd0, s2_rd_data}, 32'h5A);
    step();
    chk("s2_ack_c4", {31'd0, s2_gi[9]}, 32'd1);
    chk("s2_rx_level_nodup", {29'd0, s2_rxl}, 32'd1);

    // ---------------- table: downlink/uplink basics and TX full ----------------
    //             wv  wd     rr  gpio_out       gpio_in        tx    rx    wr    rv    rd
    tbl[0]  = mk(1'b1, 8'hA5, 1'b0, 32'h000, 32'h000, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[1]  = mk(1'b0, 8'h00, 1'b0, 32'h000, 32'h1A5, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[2]  = mk(1'b1, 8'h5A, 1'b0, 32'h000, 32'h1A5, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 32'h000, 32'h1A5, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 32'h200, 32'h1A5, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 8'h00, 1'b0, 32'h200, 32'h05A, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[6]  = mk(1'b0, 8'h00, 1'b0, 32'h000, 32'h05A, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h25A, 3'd0, 3'd1, 1'b1, 1'b1, 8'h3C);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h25A, 3'd0, 3'd1, 1'b1, 1'b1, 8'h3C);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 32'h13C, 32'h25A, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[10] = mk(1'b1, 8'h11, 1'b0, 32'h13C, 32'h25A, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[11] = mk(1'b1, 8'h22, 1'b0, 32'h13C, 32'h311, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[12] = mk(1'b1, 8'h33, 1'b0, 32'h13C, 32'h311, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[13] = mk(1'b1, 8'h44, 1'b0, 32'h13C, 32'h311, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[14] = mk(1'b1, 8'h55, 1'b0, 32'h13C, 32'h311, 3'd4, 3'd0, 1'b0, 1'b0, 8'h00);
    tbl[15] = mk(1'b1, 8'h66, 1'b0, 32'h13C, 32'h311, 3'd4, 3'd0, 1'b0, 1'b0, 8'h00);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h311, 3'd4, 3'd0, 1'b0, 1'b0, 8'h00);
    tbl[17] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h222, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[18] = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h222, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[19] = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h333, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[20] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h333, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[21] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h244, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[22] = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h244, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[23] = mk(1'b0, 8'h00, 1'b0, 32'h13C, 32'h355, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[24] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h355, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    tbl[25] = mk(1'b0, 8'h00, 1'b0, 32'h33C, 32'h355, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 26; i++) begin
      wv = tbl[i].wv; wd = tbl[i].wd; rr = tbl[i].rr; go = tbl[i].go;
      step();
      chk($sformatf("row%0d_gpio_in", i), gi, tbl[i].egi);
      chk($sformatf("row%0d_tx_level", i), {29'd0, txl}, {29'd0, tbl[i].etx});
      chk($sformatf("row%0d_rx_level", i), {29'd0, rxl}, {29'd0, tbl[i].erx});
      chk($sformatf("row%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, tbl[i].ewr});
      chk($sformatf("row%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].erv});
      if (tbl[i].erv) begin
        chk($sformatf("row%0d_rd_data", i), {24'd0, rd_data}, {24'd0, tbl[i].erd});
      end
    end
    wv = 1'b0; rr = 1'b0;

    // ---------------- RX full holds off uplink ----------------
    upr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      upr = ~upr;
      go  = {22'd0, 1'b1, upr, 8'hA0 + 8'(k)};
      step();
    end
    chk("rxfull_level", {29'd0, rxl}, 32'd4);
    chk("rxfull_ack_before", {31'd0, gi[9]}, 32'd1);
    upr = ~upr;
    go  = {22'd0, 1'b1, upr, 8'h3C};
    step();
    chk("rxfull_hold_ack", {31'd0, gi[9]}, 32'd1);
    chk("rxfull_hold_level", {29'd0, rxl}, 32'd4);
    step();
    chk("rxfull_hold_ack2", {31'd0, gi[9]}, 32'd1);
    chk("rxfull_head", {24'd0, rd_data}, 32'hA0);
    rr = 1'b1;
    step();
    chk("rxpop_ack_toggled", {31'd0, gi[9]}, 32'd0);
    chk("rxpop_level", {29'd0, rxl}, 32'd4);
    exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rxdrain%0d_data", k), {24'd0, rd_data}, {24'd0, exp_q[k]});
      step();
    end
    rr = 1'b0;
    chk("rxdrain_level", {29'd0, rxl}, 32'd0);
    chk("rxdrain_valid", {31'd0, rd_valid}, 32'd0);

    // ---------------- flush with WAIT_ACK pending ----------------
    go = {22'd0, 1'b1, upr, 8'h00};
    wv = 1'b1;
    wd = 8'hB1; step();
    wd = 8'hB2; step();
    wd = 8'hB3; step();
    wd = 8'hB4; step();
    wv = 1'b0;
    chk("pre_flush_tx", {29'd0, txl}, 32'd3);
    chk("pre_flush_gpio", gi, 32'h0B1);
    for (int k = 0; k < 3; k++) begin
      upr = ~upr;
      go  = {22'd0, 1'b1, upr, 8'hC1 + 8'(k)};
      step();
    end
    chk("pre_flush_rx", {29'd0, rxl}, 32'd3);
    chk("pre_flush_gpio2", gi, 32'h2B1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_tx", {29'd0, txl}, 32'd0);
    chk("flush_rx", {29'd0, rxl}, 32'd0);
    chk("flush_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("flush_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("flush_gpio_kept", gi, 32'h2B1);
    step();
    chk("post_flush_gpio", gi, 32'h2B1);
    go = {22'd0, 1'b0, upr, 8'hC3};
    step();
    chk("flush_ack_gpio", gi, 32'h2B1);
    wv = 1'b1; wd = 8'hD7;
    step();
    wv = 1'b0;
    step();
    chk("after_flush_next", gi, 32'h3D7);
    chk("after_flush_tx", {29'd0, txl}, 32'd0);

    // ---------------- async reset mid-transfer ----------------
    wv = 1'b1;
    wd = 8'hE1; step();
    wd = 8'hE2; step();
    wv = 1'b0;
    chk("pre_reset_tx", {29'd0, txl}, 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("areset_gpio_in", gi, 32'h0);
    chk("areset_tx", {29'd0, txl}, 32'd0);
    chk("areset_rx", {29'd0, rxl}, 32'd0);
    chk("areset_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("areset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("areset_s2_gpio_in", s2_gi, 32'h0);
    go = 32'h0; s2_go = 32'h0;
    #3 resetn = 1'b1;
    step();
    wv = 1'b1; wd = 8'h77;
    step();
    wv = 1'b0;
    step();
    chk("post_reset_xfer", gi, 32'h177);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_comm_bridge.md
GPIO_COMM_BRIDGE -- requirements
Module: gpio_comm_bridge

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8: payload bits per transfer; legal range 1..30.
REQ-002 SHALL have parameter pDEPTH, default 4: entries per FIFO; power of two, 2..64.
REQ-003 SHALL have parameter pSYNC, default 0: register stages on gpio_out; legal values 0 or 2.
REQ-004 SHALL have the following ports; LW denotes $clog2(pDEPTH)+1.
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both FIFOs.
- host_wr_valid  in  1  host offers a byte to send to the core.
- host_wr_data  in  pDATA_WIDTH  payload toward the core.
- host_wr_ready  out  1  TX FIFO can accept.
- host_rd_valid  out  1  RX FIFO non-empty.
- host_rd_data  out  pDATA_WIDTH  RX FIFO head.
- host_rd_ready  in  1  host pops RX head.
- gpio_out  in  32  core GPIO outputs.
- gpio_in  out  32  core GPIO inputs.
- tx_level  out  LW  TX occupancy.
- rx_level  out  LW  RX occupancy.

Function
REQ-005 SHALL use this gpio_out map: [pDATA_WIDTH-1:0] up_data; [pDATA_WIDTH] up_req toggle; [pDATA_WIDTH+1] dn_ack toggle; all other bits ignored.
REQ-006 SHALL use this gpio_in map: [pDATA_WIDTH-1:0] dn_data; [pDATA_WIDTH] dn_req toggle; [pDATA_WIDTH+1] up_ack toggle; all other bits driven 0.
REQ-007 SHALL, when pSYNC=2, pass gpio_out through two flops before use; when pSYNC=0, use gpio_out directly.
REQ-008 SHALL assert host_wr_ready = !tx_full and push host_wr_data on host_wr_valid && host_wr_ready; a write while full SHALL be ignored.
REQ-009 SHALL drive host_rd_valid = !rx_empty and host_rd_data = RX head (first-word fall-through); pop on host_rd_valid && host_rd_ready.
REQ-010 SHALL allow a simultaneous push and pop on the same FIFO in one cycle, including when it is full or empty-with-bypass-excluded; the level is unchanged.
REQ-011 SHALL implement a downlink FSM with states IDLE and WAIT_ACK.
REQ-012 SHALL, in IDLE with TX non-empty, pop the head, register it onto dn_data, toggle dn_req, and go to WAIT_ACK; a push in cycle N SHALL become visible on gpio_in in cycle N+2 when the FSM is idle.
REQ-013 SHALL hold dn_data stable in WAIT_ACK and return to IDLE in the cycle after dn_ack (post-sync) equals dn_req.
REQ-014 SHALL detect an uplink request when up_req (post-sync) != up_ack.
REQ-015 SHALL, on an uplink request with RX not full, write up_data into RX and toggle up_ack on the same edge; with RX full, hold off without loss until space exists.
REQ-016 SHALL never drop or duplicate a payload in either direction.
REQ-017 SHALL make flush empty both FIFOs and zero both levels, while leaving the toggle registers and FSM state untouched so in-flight handshakes complete.
REQ-018 SHALL give flush priority over a push or pop in the same cycle.
REQ-019 SHALL wrap FIFO pointers modulo pDEPTH, and derive full/empty from the LW-bit level count.

Reset
REQ-020 SHALL, while resetn=0, asynchronously clear all of the following: FIFOs (empty), levels (0), gpio_in (0x00000000), toggles (0), FSM (IDLE), sync flops (0), host_rd_valid (0); host_wr_ready SHALL read 1.
REQ-021 SHALL abandon any in-flight transfer on reset mid-operation; the core is reset together with the bridge.

Verification
REQ-022 SHALL cover: pDATA_WIDTH=8, pSYNC=0; push 0xA5 at cycle N -> gpio_in[7:0]=0xA5 and gpio_in[8]=1 at N+2; drive gpio_out[9]=1 -> next push is presented after ack.
REQ-023 SHALL cover: pDEPTH=4, no core ack, push 6 bytes -> 0x11 is on gpio_in, 4 are buffered, tx_level=4, host_wr_ready=0, and the 6th write is ignored.
REQ-024 SHALL cover: core sets gpio_out[7:0]=0x3C and toggles bit 8 with RX full -> gpio_in[9] unchanged; after one pop, 0x3C enters RX and gpio_in[9] toggles.
REQ-025 SHALL cover: pSYNC=2, uplink toggle -> up_ack toggles exactly 3 cycles later (2 sync stages plus 1 register).
REQ-026 SHALL cover: flush asserted with 3 bytes queued in each FIFO and WAIT_ACK pending -> both levels read 0 next cycle; the pending dn_req is still completed by an ack.
REQ-027 SHALL cover: resetn pulsed low mid-transfer -> gpio_in=0, both levels 0, host_wr_ready=1, asynchronously without waiting for a clock edge.
